// File: rtl/decode_stage_hz.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_hz (with rv32i_pkg)
// Description : RV32I decode stage - register file with write-first bypass,
//               immediate/control decode and a stallable, flushable D->E reg.
// Revision    : 1.0 - initial release
// ============================================================================

package rv32i_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;
endpackage

module decode_stage_hz
    import rv32i_pkg::*;
#(
    parameter int DPW = 32,
    parameter int ADW = 5
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic [DPW-1:0] instrD,
    input  logic           validD,
    input  logic           stallD,
    input  logic           flushE,
    input  logic [ADW-1:0] addr_3,
    input  logic [DPW-1:0] wd_3,
    input  logic           we,
    output logic           validE,
    output logic           resultsrcE,
    output logic           memwriteE,
    output logic           alusrcE,
    output logic           regwriteE,
    output alu_op_t        alu_ctrlE,
    output logic [DPW-1:0] srcA,
    output logic [DPW-1:0] Rd2E,
    output logic [ADW-1:0] Rs1E,
    output logic [ADW-1:0] Rs2E,
    output logic [ADW-1:0] RdE,
    output logic [DPW-1:0] immextE,
    output logic           illegalE
);

    localparam int       c_NREG = 2**ADW;
    localparam bit [6:0] c_OP_R = 7'b0110011;
    localparam bit [6:0] c_OP_I = 7'b0010011;
    localparam bit [6:0] c_OP_L = 7'b0000011;
    localparam bit [6:0] c_OP_S = 7'b0100011;

    // An all-zero value of this struct is the bubble (ALU_ADD encodes as 0)
    typedef struct packed {
        logic           valid;
        logic           resultsrc;
        logic           memwrite;
        logic           alusrc;
        logic           regwrite;
        alu_op_t        alu;
        logic           illegal;
        logic [DPW-1:0] srca;
        logic [DPW-1:0] rd2;
        logic [ADW-1:0] rs1;
        logic [ADW-1:0] rs2;
        logic [ADW-1:0] rd;
        logic [DPW-1:0] imm;
    } de_t;

    logic [DPW-1:0] r_rf [c_NREG];
    de_t            r_e;
    de_t            w_dec;
    alu_op_t        w_alu;
    logic [31:0]    w_instr;
    logic [6:0]     w_op;
    logic [2:0]     w_f3;
    logic           w_f7b5;
    logic [ADW-1:0] w_rs1;
    logic [ADW-1:0] w_rs2;
    logic [ADW-1:0] w_rd;
    logic           w_wr_hit;
    logic [DPW-1:0] w_rd1_val;
    logic [DPW-1:0] w_rd2_val;
    logic [DPW-1:0] w_imm_i;
    logic [DPW-1:0] w_imm_s;

    assign w_instr  = instrD[31:0];
    assign w_op     = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7b5   = w_instr[30];
    assign w_rs1    = ADW'(w_instr[19:15]);
    assign w_rs2    = ADW'(w_instr[24:20]);
    assign w_rd     = ADW'(w_instr[11:7]);
    assign w_wr_hit = we && (addr_3 != '0);
    assign w_imm_i  = {{(DPW-12){w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s  = {{(DPW-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_rf[addr_3] <= wd_3;
        end
    end

    // Write-first: a same-cycle write-back wins over the stored value
    always_comb begin
        if (w_rs1 == '0)                        w_rd1_val = '0;
        else if (w_wr_hit && addr_3 == w_rs1)   w_rd1_val = wd_3;
        else                                    w_rd1_val = r_rf[w_rs1];
        if (w_rs2 == '0)                        w_rd2_val = '0;
        else if (w_wr_hit && addr_3 == w_rs2)   w_rd2_val = wd_3;
        else                                    w_rd2_val = r_rf[w_rs2];
    end

    always_comb begin
        w_alu = ALU_ADD;
        case (w_f3)
            3'b000:  w_alu = (w_op == c_OP_R && w_f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu = ALU_SLL;
            3'b010:  w_alu = ALU_SLT;
            3'b011:  w_alu = ALU_SLTU;
            3'b100:  w_alu = ALU_XOR;
            3'b101:  w_alu = w_f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu = ALU_OR;
            default: w_alu = ALU_AND;
        endcase
    end

    always_comb begin
        w_dec       = '0;
        w_dec.valid = 1'b1;
        w_dec.srca  = w_rd1_val;
        w_dec.rd2   = w_rd2_val;
        w_dec.rs1   = w_rs1;
        w_dec.rs2   = w_rs2;
        w_dec.rd    = w_rd;
        case (w_op)
            c_OP_R: begin
                w_dec.regwrite = 1'b1;
                w_dec.alu      = w_alu;
            end
            c_OP_I: begin
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.alu      = w_alu;
                w_dec.imm      = w_imm_i;
            end
            c_OP_L: begin
                w_dec.regwrite  = 1'b1;
                w_dec.alusrc    = 1'b1;
                w_dec.resultsrc = 1'b1;
                w_dec.imm       = w_imm_i;
            end
            c_OP_S: begin
                w_dec.memwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.imm      = w_imm_s;
            end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    // While stalled only the operands track write-back; control stays frozen
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_e <= '0;
        end else if (flushE) begin
            r_e <= '0;
        end else if (stallD) begin
            if (w_wr_hit && addr_3 == r_e.rs1) r_e.srca <= wd_3;
            if (w_wr_hit && addr_3 == r_e.rs2) r_e.rd2  <= wd_3;
        end else begin
            r_e <= validD ? w_dec : '0;
        end
    end

    assign validE     = r_e.valid;
    assign resultsrcE = r_e.resultsrc;
    assign memwriteE  = r_e.memwrite;
    assign alusrcE    = r_e.alusrc;
    assign regwriteE  = r_e.regwrite;
    assign alu_ctrlE  = r_e.alu;
    assign illegalE   = r_e.illegal;
    assign srcA       = r_e.srca;
    assign Rd2E       = r_e.rd2;
    assign Rs1E       = r_e.rs1;
    assign Rs2E       = r_e.rs2;
    assign RdE        = r_e.rd;
    assign immextE    = r_e.imm;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hz.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_hz
// Description : Directed vector bench for decode_stage_hz (default DPW/ADW).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_hz;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] instrD;
    logic        validD, stallD, flushE, we;
    logic [4:0]  addr_3;
    logic [31:0] wd_3;
    logic        validE, resultsrcE, memwriteE, alusrcE, regwriteE, illegalE;
    alu_op_t     alu_ctrlE;
    logic [31:0] srcA, Rd2E, immextE;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        vld;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        ev;
        logic [3:0]  ectrl;   // {resultsrc, memwrite, alusrc, regwrite}
        alu_op_t     ealu;
        logic        eill;
        logic [31:0] esa;
        logic [31:0] erd2;
        logic [4:0]  erd;
        logic [31:0] eimm;
        logic [4:0]  ers1;
        logic [4:0]  ers2;
    } vec_t;

    vec_t vec [11];
    vec_t zero_v;

    decode_stage_hz #(.DPW(32), .ADW(5)) dut (
        .clk(clk), .arst_n(arst_n), .instrD(instrD), .validD(validD),
        .stallD(stallD), .flushE(flushE), .addr_3(addr_3), .wd_3(wd_3), .we(we),
        .validE(validE), .resultsrcE(resultsrcE), .memwriteE(memwriteE),
        .alusrcE(alusrcE), .regwriteE(regwriteE), .alu_ctrlE(alu_ctrlE),
        .srcA(srcA), .Rd2E(Rd2E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .immextE(immextE), .illegalE(illegalE)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".validE"},  32'(validE), 32'(v.ev));
        check({tag, ".ctrl"},    32'({resultsrcE, memwriteE, alusrcE, regwriteE}), 32'(v.ectrl));
        check({tag, ".alu"},     32'(alu_ctrlE), 32'(v.ealu));
        check({tag, ".illegal"}, 32'(illegalE), 32'(v.eill));
        check({tag, ".srcA"},    srcA, v.esa);
        check({tag, ".Rd2E"},    Rd2E, v.erd2);
        check({tag, ".RdE"},     32'(RdE), 32'(v.erd));
        check({tag, ".immextE"}, immextE, v.eimm);
        check({tag, ".Rs1E"},    32'(Rs1E), 32'(v.ers1));
        check({tag, ".Rs2E"},    32'(Rs2E), 32'(v.ers2));
    endtask

    task automatic drive(input logic [31:0] ins, input logic vld, input logic w,
                         input logic [4:0] a, input logic [31:0] d,
                         input logic st, input logic fl);
        @(negedge clk);
        instrD = ins; validD = vld; we = w; addr_3 = a; wd_3 = d;
        stallD = st; flushE = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        zero_v = '{32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 4'b0000, ALU_ADD, 1'b0,
                   32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0};
        // instr, vld, we, a3, wd | valid, ctrl, alu, ill, srcA, Rd2E, RdE, imm, Rs1E, Rs2E
        vec[0]  = '{32'h00700293, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 4'b0011, ALU_ADD,  1'b0, 32'h0,    32'h0,    5'd5,  32'h7,        5'd0, 5'd7};
        vec[1]  = '{32'h00318233, 1'b1, 1'b1, 5'd3, 32'h1234, 1'b1, 4'b0001, ALU_ADD,  1'b0, 32'h1234, 32'h1234, 5'd4,  32'h0,        5'd3, 5'd3};
        vec[2]  = '{32'h00300333, 1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b1, 4'b0001, ALU_ADD,  1'b0, 32'h0,    32'h1234, 5'd6,  32'h0,        5'd0, 5'd3};
        vec[3]  = '{32'hFE20AE23, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 4'b0110, ALU_ADD,  1'b0, 32'h0,    32'h0,    5'd28, 32'hFFFFFFFC, 5'd1, 5'd2};
        vec[4]  = '{32'h403183B3, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 4'b0001, ALU_SUB,  1'b0, 32'h1234, 32'h1234, 5'd7,  32'h0,        5'd3, 5'd3};
        vec[5]  = '{32'h4041D413, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 4'b0011, ALU_SRA,  1'b0, 32'h1234, 32'h0,    5'd8,  32'h404,      5'd3, 5'd4};
        vec[6]  = '{32'h0011B493, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 4'b0011, ALU_SLTU, 1'b0, 32'h1234, 32'h0,    5'd9,  32'h1,        5'd3, 5'd1};
        vec[7]  = '{32'h0081A503, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 4'b1011, ALU_ADD,  1'b0, 32'h1234, 32'h0,    5'd10, 32'h8,        5'd3, 5'd8};
        vec[8]  = '{32'h0000006F, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 4'b0000, ALU_ADD,  1'b1, 32'h0,    32'h0,    5'd0,  32'h0,        5'd0, 5'd0};
        vec[9]  = '{32'h00700293, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 4'b0000, ALU_ADD,  1'b0, 32'h0,    32'h0,    5'd0,  32'h0,        5'd0, 5'd0};
        vec[10] = '{32'h0051F5B3, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 4'b0001, ALU_AND,  1'b0, 32'h1234, 32'h0,    5'd11, 32'h0,        5'd3, 5'd5};

        arst_n = 1'b0; instrD = '0; validD = 1'b0; stallD = 1'b0; flushE = 1'b0;
        we = 1'b0; addr_3 = '0; wd_3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", zero_v);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vec[i].instr, vec[i].vld, vec[i].we, vec[i].a3, vec[i].wd, 1'b0, 1'b0);
            check_all($sformatf("vec%0d", i), vec[i]);
        end

        // Stall with ADD x4,x3,x3 held; write-back to x3 refreshes both operands
        drive(32'h00318233, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        check("stall.pre_srcA", srcA, 32'h1234);
        drive(32'h00700293, 1'b1, 1'b1, 5'd3, 32'hAA, 1'b1, 1'b0);
        check_all("stall.refresh", '{32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 4'b0001, ALU_ADD, 1'b0,
                                     32'hAA, 32'hAA, 5'd4, 32'h0, 5'd3, 5'd3});
        drive(32'h00700293, 1'b1, 1'b1, 5'd5, 32'h55, 1'b1, 1'b0);
        check("stall.other_srcA", srcA, 32'hAA);
        check("stall.other_RdE", 32'(RdE), 32'd4);
        drive(32'h00700293, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        check("stallflush.validE", 32'(validE), 32'd0);
        check("stallflush.regwriteE", 32'(regwriteE), 32'd0);
        check("stallflush.srcA", srcA, 32'h0);

        // Asynchronous reset in the middle of a cycle, then x3 must read 0
        drive(32'h0000006F, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        check("jal.illegal", 32'(illegalE), 32'd1);
        @(negedge clk);
        validD = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        check_all("async_rst", zero_v);
        @(negedge clk);
        arst_n = 1'b1;
        drive(32'h00318233, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        check("post_rst.srcA", srcA, 32'h0);
        check("post_rst.Rd2E", Rd2E, 32'h0);
        check("post_rst.validE", 32'(validE), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
